// File: rtl/bank_sram_write_scheduler.sv
// Round-robin write scheduler for a banked XOR-swizzled SRAM: arbitrates requesters, holds swizzle config,
// registers row/data for the butterfly and emits pre-permuted bank write enables. Optional: BANK_WRITE_STAT_EN.
module bank_sram_write_scheduler #(
    parameter int BW     = 8,
    parameter int NDATA  = 32,
    parameter int NBANK  = 16,
    parameter int XOR_BW = 4,
    parameter int NREQ   = 2,
    localparam int CLOG2_NDATA  = $clog2(NDATA),
    localparam int CLOG2_NBANK  = $clog2(NBANK),
    localparam int CLOG2_XOR_BW = $clog2(XOR_BW),
    localparam int CLOG2_NREQ   = $clog2(NREQ)
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_cfg_rdy,
    output logic                                          o_cfg_ack,
    input  logic [CLOG2_NBANK-1:0]                        i_cfg_xor_mask,
    input  logic [CLOG2_NBANK-1:0][CLOG2_XOR_BW-1:0]      i_cfg_xor_scheme,
    input  logic [NREQ-1:0]                               i_req_rdy,
    output logic [NREQ-1:0]                               o_req_ack,
    input  logic [NREQ-1:0][CLOG2_NDATA-1:0]              i_req_hiaddr,
    input  logic [NREQ-1:0][NBANK-1:0]                    i_req_bank_en,
    input  logic [NREQ-1:0][NBANK-1:0][BW-1:0]            i_req_data,
    output logic [CLOG2_NBANK-1:0]                        o_xor_mask,
    output logic [CLOG2_NBANK-1:0][CLOG2_XOR_BW-1:0]      o_xor_scheme,
    output logic [CLOG2_NDATA-1:0]                        o_bf_hiaddr,
    output logic [NBANK-1:0][BW-1:0]                      o_bf_data,
    output logic [NBANK-1:0]                              o_sram_we,
    output logic                                          o_busy
`ifdef BANK_WRITE_STAT_EN
    ,
    output logic [NREQ-1:0][15:0]                         o_grant_cnt
`endif
);

    typedef enum logic [1:0] {UNCFG, RUN, DRAIN} state_t;

    state_t                        state, state_nxt;
    logic [CLOG2_NREQ-1:0]         rr_ptr, rr_ptr_nxt;
    logic                          grant_vld;
    logic [NREQ-1:0]               req_ack;
    logic                          cfg_ack;

    logic [CLOG2_NDATA-1:0]        sel_hiaddr;
    logic [NBANK-1:0]              sel_bank_en;
    logic [NBANK-1:0][BW-1:0]      sel_data;
    logic [CLOG2_NBANK-1:0]        swz_bits;
    logic [CLOG2_NBANK-1:0]        swz;
    logic [NBANK-1:0]              perm_we;

    // Config wins over requests; DRAIN waits until the output stage holds no enabled write.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        cfg_ack    = 1'b0;
        req_ack    = '0;
        grant_vld  = 1'b0;
        case (state)
            UNCFG: begin
                cfg_ack = i_cfg_rdy;
                if (i_cfg_rdy)
                    state_nxt = RUN;
            end
            RUN: begin
                if (i_cfg_rdy) begin
                    state_nxt = DRAIN;
                end else begin
                    for (int off = 0; off < NREQ; off++) begin
                        for (int k = 0; k < NREQ; k++) begin
                            if (!grant_vld && k == (int'(rr_ptr) + off) % NREQ && i_req_rdy[k]) begin
                                grant_vld  = 1'b1;
                                req_ack[k] = 1'b1;
                                rr_ptr_nxt = CLOG2_NREQ'((k + 1) % NREQ);
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (!i_cfg_rdy) begin
                    state_nxt = RUN;
                end else if (o_sram_we == '0) begin
                    cfg_ack   = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = UNCFG;
        endcase
    end

    always_comb begin
        sel_hiaddr  = '0;
        sel_bank_en = '0;
        sel_data    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_ack[k]) begin
                sel_hiaddr  = i_req_hiaddr[k];
                sel_bank_en = i_req_bank_en[k];
                sel_data    = i_req_data[k];
            end
        end
    end

    // Enables are pre-swizzled so bank j sees the enable of the logical bank the butterfly routes to it.
    always_comb begin
        swz_bits = '0;
        for (int i = 0; i < CLOG2_NBANK; i++) begin
            for (int s = 0; s < CLOG2_NDATA; s++) begin
                if (int'(o_xor_scheme[i]) % CLOG2_NDATA == s)
                    swz_bits[i] = sel_hiaddr[s];
            end
        end
        swz     = o_xor_mask & swz_bits;
        perm_we = '0;
        for (int j = 0; j < NBANK; j++)
            perm_we[j] = sel_bank_en[CLOG2_NBANK'(j) ^ swz];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= UNCFG;
            rr_ptr       <= '0;
            o_xor_mask   <= '0;
            o_xor_scheme <= '0;
            o_bf_hiaddr  <= '0;
            o_bf_data    <= '0;
            o_sram_we    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (cfg_ack) begin
                o_xor_mask   <= i_cfg_xor_mask;
                o_xor_scheme <= i_cfg_xor_scheme;
            end
            if (grant_vld) begin
                o_bf_hiaddr <= sel_hiaddr;
                o_bf_data   <= sel_data;
                o_sram_we   <= perm_we;
            end else begin
                o_sram_we   <= '0;
            end
        end
    end

`ifdef BANK_WRITE_STAT_EN
    // Saturating per-requester grant counters, cleared with every new config.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (i_rst || cfg_ack)
                o_grant_cnt[k] <= '0;
            else if (req_ack[k] && o_grant_cnt[k] != 16'hFFFF)
                o_grant_cnt[k] <= o_grant_cnt[k] + 16'd1;
        end
    end
`endif

    assign o_cfg_ack = cfg_ack;
    assign o_req_ack = req_ack;
    assign o_busy    = (state != RUN);

endmodule
